// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the stream multiplexor family.
package stream_mux_rr_pkg;

  localparam int MUX_MODE_FIXED = 0;
  localparam int MUX_MODE_RR    = 1;

  // Next channel index after idx, wrapping from nch-1 back to 0.
  function automatic int wrap_inc(input int idx, input int nch);
    return (idx >= nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Fixed-priority / round-robin arbiter with one-hot and binary grant outputs.
// The round-robin pointer lives here and advances past each granted channel.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = MUX_MODE_RR,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] ptr_r;
  logic [SELW-1:0] best_s;
  logic [NCH-1:0]  gnt_s;
  logic            found_s;
  int              start_s;
  int              dist_s;
  int              best_dist_s;

  // Winner is the requester at the smallest circular distance from the start index.
  always_comb begin
    start_s     = (MODE == MUX_MODE_RR) ? int'(ptr_r) : 0;
    found_s     = 1'b0;
    best_s      = '0;
    best_dist_s = NCH;
    dist_s      = 0;
    gnt_s       = '0;
    for (int i = 0; i < NCH; i++) begin
      dist_s = (i >= start_s) ? (i - start_s) : (i - start_s + NCH);
      if (en && req[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        best_s      = SELW'(i);
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      gnt_s[i] = found_s && (int'(best_s) == i);
    end
  end

  assign gnt     = gnt_s;
  assign gnt_idx = best_s;

  // Round-robin pointer: moves just past the granted channel, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (found_s && (MODE == MUX_MODE_RR)) begin
      ptr_r <= SELW'(wrap_inc(int'(best_s), NCH));
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// NCH-input valid/ready stream multiplexor with arbitration and a registered
// output stage that reloads in the same cycle it drains.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int MODE  = MUX_MODE_RR,
  parameter int SELW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]     in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             accept_s;
  logic             en_s;
  logic [NCH-1:0]   gnt_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic [WIDTH-1:0] mux_data_s;

  assign accept_s = ~out_valid | out_ready;
  // Gating with rst keeps in_ready low for the whole reset interval.
  assign en_s     = accept_s & ~rst;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE),
    .SELW (SELW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .en      (en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign in_ready = gnt_s;

  // One-hot selected data path.
  always_comb begin
    mux_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_s[i]) begin
        mux_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        mux_data_s = mux_data_s;
      end
    end
  end

  // Output register: load on grant, empty on drain without grant, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (|gnt_s) begin
      out_valid <= 1'b1;
      out_data  <= mux_data_s;
      out_sel   <= gnt_idx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
